ring_johnson_counter: RTL and testbench
=======================================

RING_JOHNSON_COUNTER -- requirements
Module: ring_johnson_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  advance one step this cycle.
REQ-005 SHALL have port mode  input  1  0 = Johnson (twisted ring), 1 = ring (one-hot).
REQ-006 SHALL have port dir  input  1  0 = right shift, 1 = left shift.
REQ-007 SHALL have port load  input  1  synchronous parallel load.
REQ-008 SHALL have port load_val  input  WIDTH  value written on load.
REQ-009 SHALL have port q  output  WIDTH  counter register.
REQ-010 SHALL have port state_idx  output  $clog2(2*WIDTH)  sequence index of q.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse on arrival at home state.
REQ-012 SHALL have port illegal  output  1  combinational: q is not legal for the current mode.

Function
REQ-013 Priority SHALL be reset > load > en; with none active, q holds.
REQ-014 Johnson step SHALL be: right q <= {~q[0], q[W-1:1]}; left q <= {q[W-2:0], ~q[W-1]}.
REQ-015 Ring step SHALL be: right q <= {q[0], q[W-1:1]}; left q <= {q[W-2:0], q[W-1]}.
REQ-016 Johnson-legal SHALL mean at most one adjacent bit pair with q[i] != q[i+1], giving 2*WIDTH legal states.
REQ-017 Ring-legal SHALL mean exactly one bit set.
REQ-018 Home state SHALL be all-zeros in Johnson mode and 0...01 in ring mode.
REQ-019 When en=1, load=0 and q is illegal, q SHALL be loaded with the home state of the current mode instead of stepping.
REQ-020 Load SHALL write load_val verbatim, even if illegal; correction occurs on the next enabled cycle.
REQ-021 Johnson state_idx SHALL be popcount(q) if q[W-1]=1 or q=0, else 2*WIDTH - popcount(q).
REQ-022 Ring state_idx SHALL be (WIDTH - position of the set bit) mod WIDTH.
REQ-023 state_idx SHALL be 0 whenever illegal=1.
REQ-024 Right shifts SHALL increment state_idx modulo the sequence length; left shifts SHALL decrement it.
REQ-025 wrap SHALL assert for exactly one cycle after a normal step lands on home, in either direction.
REQ-026 wrap SHALL NOT assert after a load or a correction.
REQ-027 A mode change mid-count SHALL take effect immediately: legality, index and next step all use the new mode; an illegal result is corrected per REQ-019.
REQ-028 A dir change SHALL take effect on the next enabled step, with no extra latency.

Reset
REQ-029 On reset, q SHALL be 0 and wrap SHALL be 0, asynchronously.
REQ-030 After reset in ring mode, illegal=1 until the first enabled cycle loads 0...01.
REQ-031 Reset asserted mid-count or mid-load SHALL override all other inputs.

Structure
REQ-032 Package shift_counter_pkg SHALL hold the mode constants (MODE_JOHNSON=0, MODE_RING=1), the dir constants (DIR_RIGHT=0, DIR_LEFT=1) and an index-width function.
REQ-033 Legality check and index decode SHALL live in a combinational sub-module, shift_counter_decode, instanced once.
REQ-034 q and wrap SHALL be the only state elements.

Verification (WIDTH=4)
REQ-035 Johnson, right, en=1 for 8 cycles from reset SHALL give q = 1000,1100,1110,1111,0111,0011,0001,0000 and state_idx = 1..7,0, with wrap only after the 8th step.
REQ-036 Johnson, left, from reset SHALL give q = 0001,0011,0111,1111,1110,1100,1000,0000 and state_idx = 7,6,...,1,0.
REQ-037 Ring, right, from reset: cycle 1 SHALL correct 0000 to 0001 with wrap=0; following steps SHALL give 1000,0100,0010,0001, with wrap after the 4th step.
REQ-038 Load 0101 in Johnson mode SHALL give illegal=1 and state_idx=0; the next en SHALL give q=0000 with wrap=0.
REQ-039 load=1 and en=1 together with load_val=1100 SHALL give q=1100; switching mode to ring with en=1 SHALL then give q=0001.
REQ-040 Reset asserted asynchronously between clock edges at q=1110 SHALL force q=0000 immediately, with no wrap pulse.

Source files
------------

// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson shift counter.
// Mode and direction encodings match the raw values on the mode/dir pins.
package shift_counter_pkg;

   localparam logic MODE_JOHNSON = 1'b0;
   localparam logic MODE_RING    = 1'b1;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Width of an index covering the longest (Johnson) sequence of 2*width states.
   function automatic int idx_width(input int width);
      return $clog2(2 * width);
   endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational legality check and sequence-index decode of the counter register.
// Reports index 0 for any state that is not legal in the selected mode.
module shift_counter_decode
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IW    = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] q,
   input  logic             mode,
   output logic             illegal,
   output logic [IW-1:0]    state_idx
);

   logic [WIDTH-2:0] edges;
   int pop;
   int n_edges;
   int pos;
   int j_idx;
   int r_idx;
   logic j_legal;
   logic r_legal;

   // A Johnson state is a single run of ones against zeros: at most one boundary.
   for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
      assign edges[gi] = q[gi] ^ q[gi+1];
   end

   always_comb begin
      pop     = 0;
      n_edges = 0;
      pos     = 0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + int'(q[i]);
         if (q[i]) pos = i;
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         n_edges = n_edges + int'(edges[i]);
      end

      j_legal = (n_edges <= 1);
      r_legal = (pop == 1);

      // Filling phase has the MSB set; draining phase counts back from 2*WIDTH.
      j_idx = (q[WIDTH-1] || pop == 0) ? pop : (2 * WIDTH - pop);
      r_idx = (WIDTH - pos) % WIDTH;

      illegal   = (mode == MODE_RING) ? !r_legal : !j_legal;
      state_idx = '0;
      if (!illegal) begin
         state_idx = IW'((mode == MODE_RING) ? r_idx : j_idx);
      end
   end

endmodule

// File: rtl/ring_johnson_counter.sv
// Shift counter running either as a Johnson (twisted ring) or one-hot ring counter.
// Illegal states self-correct to the mode's home state on the next enabled cycle.
module ring_johnson_counter
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         mode,
   input  logic                         dir,
   input  logic                         load,
   input  logic [WIDTH-1:0]             load_val,
   output logic [WIDTH-1:0]             q,
   output logic [idx_width(WIDTH)-1:0]  state_idx,
   output logic                         wrap,
   output logic                         illegal
);

   logic [WIDTH-1:0] home;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             fb_right;
   logic             fb_left;

   shift_counter_decode #(
      .WIDTH (WIDTH),
      .IW    (idx_width(WIDTH))
   ) u_decode (
      .q         (q),
      .mode      (mode),
      .illegal   (illegal),
      .state_idx (state_idx)
   );

   always_comb begin
      home = (mode == MODE_RING) ? WIDTH'(1) : '0;

      // Johnson mode inverts the bit wrapping around; ring mode passes it through.
      fb_right = q[0]       ^ (mode == MODE_JOHNSON);
      fb_left  = q[WIDTH-1] ^ (mode == MODE_JOHNSON);
      step_val = (dir == DIR_LEFT) ? {q[WIDTH-2:0], fb_left} : {fb_right, q[WIDTH-1:1]};

      q_next    = q;
      wrap_next = 1'b0;
      if (load) begin
         q_next = load_val;
      end else if (en) begin
         if (illegal) begin
            q_next = home;
         end else begin
            q_next    = step_val;
            wrap_next = (step_val == home);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Self-checking bench for ring_johnson_counter (WIDTH=4): directed sequences plus
// a randomized run checked against a sequence-table model through a scoreboard queue.
module tb_ring_johnson_counter;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         en;
   logic         mode;
   logic         dir;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic [2:0]   state_idx;
   logic         wrap;
   logic         illegal;

   typedef struct packed {
      logic [W-1:0] q;
      logic [2:0]   idx;
      logic         wrap;
      logic         illegal;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_q;
   logic         m_wrap;
   logic [W-1:0] j_seq[8];
   logic [W-1:0] r_seq[4];

   logic [W-1:0] j_right_exp[8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                    4'b0111, 4'b0011, 4'b0001, 4'b0000};
   logic [W-1:0] j_left_exp[8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
   logic [W-1:0] r_right_exp[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

   ring_johnson_counter #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mode      (mode),
      .dir       (dir),
      .load      (load),
      .load_val  (load_val),
      .q         (q),
      .state_idx (state_idx),
      .wrap      (wrap),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Model: legality and index come from membership in the enumerated sequences.
   function automatic void lookup(input logic [W-1:0] v, input logic md,
                                  output logic legal, output int idx);
      legal = 1'b0;
      idx   = 0;
      if (md) begin
         for (int i = 0; i < 4; i++) if (r_seq[i] == v) begin legal = 1'b1; idx = i; end
      end else begin
         for (int i = 0; i < 8; i++) if (j_seq[i] == v) begin legal = 1'b1; idx = i; end
      end
   endfunction

   task automatic step(input logic e, input logic m, input logic d, input logic l,
                       input logic [W-1:0] lv);
      exp_t x;
      logic legal;
      int   idx;
      int   nidx;
      int   len;
      @(negedge clk);
      en = e; mode = m; dir = d; load = l; load_val = lv;
      lookup(m_q, m, legal, idx);
      len = m ? 4 : 8;
      if (l) begin
         m_q = lv; m_wrap = 1'b0;
      end else if (e) begin
         if (!legal) begin
            m_q = m ? 4'b0001 : 4'b0000;
            m_wrap = 1'b0;
         end else begin
            nidx   = d ? (idx + len - 1) % len : (idx + 1) % len;
            m_q    = m ? r_seq[nidx] : j_seq[nidx];
            m_wrap = (nidx == 0);
         end
      end else begin
         m_wrap = 1'b0;
      end
      lookup(m_q, m, legal, idx);
      x.q       = m_q;
      x.idx     = legal ? 3'(idx) : 3'd0;
      x.wrap    = m_wrap;
      x.illegal = !legal;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      $display("t=%0t en=%0b mode=%0b dir=%0b load=%0b lv=%b -> q=%b idx=%0d wrap=%0b illegal=%0b",
               $time, e, m, d, l, lv, q, state_idx, wrap, illegal);
      check("sb_q", 32'(q), 32'(x.q));
      check("sb_idx", 32'(state_idx), 32'(x.idx));
      check("sb_wrap", 32'(wrap), 32'(x.wrap));
      check("sb_illegal", 32'(illegal), 32'(x.illegal));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; dir = 1'b0;
      @(negedge clk);
      check("rst_q", 32'(q), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      reset = 1'b0;
      m_q = '0;
      m_wrap = 1'b0;
   endtask

   initial begin
      logic cur_mode;
      j_seq[0] = '0;
      for (int i = 1; i < 8; i++) j_seq[i] = {~j_seq[i-1][0], j_seq[i-1][W-1:1]};
      for (int i = 0; i < 4; i++) r_seq[i] = 4'b0001 << ((4 - i) % 4);

      reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
      m_q = '0; m_wrap = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();
      check("rst_illegal_j", 32'(illegal), 32'd0);
      check("rst_idx", 32'(state_idx), 32'd0);

      // Johnson right from reset
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, '0);
         check("jr_q", 32'(q), 32'(j_right_exp[i]));
         check("jr_idx", 32'(state_idx), 32'((i + 1) % 8));
         check("jr_wrap", 32'(wrap), 32'(i == 7));
      end

      // Johnson left from reset
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, '0);
         check("jl_q", 32'(q), 32'(j_left_exp[i]));
         check("jl_idx", 32'(state_idx), 32'(7 - i));
      end

      // Ring right from reset: first enabled cycle corrects 0000
      do_reset();
      @(negedge clk);
      mode = 1'b1;
      #1;
      check("ring_rst_illegal", 32'(illegal), 32'd1);
      check("ring_rst_idx", 32'(state_idx), 32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("ring_fix_q", 32'(q), 32'b0001);
      check("ring_fix_wrap", 32'(wrap), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, '0);
         check("rr_q", 32'(q), 32'(r_right_exp[i]));
         check("rr_wrap", 32'(wrap), 32'(i == 3));
      end

      // Illegal load in Johnson mode, then correction without wrap
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
      check("ld_q", 32'(q), 32'b0101);
      check("ld_illegal", 32'(illegal), 32'd1);
      check("ld_idx", 32'(state_idx), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check("corr_q", 32'(q), 32'b0000);
      check("corr_wrap", 32'(wrap), 32'd0);

      // Load beats en; mode switch to ring corrects 1100
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1100);
      check("ld_en_q", 32'(q), 32'b1100);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("mode_sw_q", 32'(q), 32'b0001);

      // Asynchronous reset between clock edges at q=1110
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check("pre_async_q", 32'(q), 32'b1110);
      #3;
      reset = 1'b1;
      #1;
      check("async_q", 32'(q), 32'd0);
      check("async_wrap", 32'(wrap), 32'd0);
      do_reset();

      // Randomized run with occasional mode flips, direction changes and loads
      cur_mode = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
         step($urandom_range(0, 3) != 0, cur_mode, 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
      end

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
